// File: rtl/eq_i2c_pkg.sv
// Shared types and constants for the equalizer gain-programming I2C master.
package eq_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        ACK,
        STOP
    } i2c_state_e;

    localparam logic [6:0] EQ_SLAVE_ADDR    = 7'h6A;
    localparam logic [7:0] EQ_GAIN_REG_BASE = 8'h01;
    localparam int         EQ_NUM_BANDS     = 10;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period tick generator; held at zero while disabled so every
// transaction starts on a fresh quarter boundary.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-CLK_DIV counter while enabled, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_gain_master.sv
// Write-only I2C master: snapshots the band gains and sends them to the
// equalizer slave as one auto-increment burst (addr, pointer, gains, STOP).
module i2c_gain_master
    import eq_i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 5,
    parameter logic [6:0] SLAVE_ADDR = EQ_SLAVE_ADDR,
    parameter logic [7:0] START_REG  = EQ_GAIN_REG_BASE,
    parameter int         NUM_GAINS  = EQ_NUM_BANDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_GAINS-1:0] gain_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_error,
    output logic                   scl_out,
    output logic                   sda_oe,
    input  logic                   sda_in
);

    localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};
    localparam logic [3:0] LAST_BYTE = 4'(NUM_GAINS + 1);

    i2c_state_e             state, nxt_state;
    logic [1:0]             quarter;
    logic [2:0]             bit_cnt;
    logic [3:0]             byte_cnt;
    logic [7:0]             shreg;
    logic [7:0]             nxt_byte;
    logic [8*NUM_GAINS-1:0] gains_q;
    logic                   tick;
    logic                   accept;

    assign busy = (state != IDLE);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick)
    );

    // Byte that follows the one just acknowledged: pointer after the address,
    // then gains in ascending band order
    always_comb begin
        nxt_byte = START_REG;
        for (int k = 0; k < NUM_GAINS; k++) begin
            if (byte_cnt == 4'(k + 1))
                nxt_byte = gains_q[8*k +: 8];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    // Next-state logic and bus pin levels per quarter
    always_comb begin
        nxt_state = state;
        scl_out   = 1'b1;
        sda_oe    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // done still high means we left STOP this cycle; let it drop first
                if (start && !done) begin
                    accept    = 1'b1;
                    nxt_state = START;
                end
            end
            START: begin
                scl_out = (quarter != 2'd3);
                sda_oe  = (quarter >= 2'd2);
                if (tick && quarter == 2'd3)
                    nxt_state = BYTE;
            end
            BYTE: begin
                scl_out = quarter[1];
                sda_oe  = ~shreg[7];
                if (tick && quarter == 2'd3 && bit_cnt == 3'd7)
                    nxt_state = ACK;
            end
            ACK: begin
                scl_out = quarter[1];
                if (tick && quarter == 2'd3) begin
                    if (ack_error || byte_cnt == LAST_BYTE)
                        nxt_state = STOP;
                    else
                        nxt_state = BYTE;
                end
            end
            STOP: begin
                scl_out = (quarter != 2'd0);
                sda_oe  = (quarter <= 2'd1);
                if (tick && quarter == 2'd3)
                    nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Quarter/bit/byte counters, shift register, snapshot and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            quarter   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            gains_q   <= '0;
            ack_error <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                gains_q   <= gain_data;
                ack_error <= 1'b0;
                quarter   <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
            end else if (tick) begin
                quarter <= quarter + 2'd1;
                case (state)
                    START: if (quarter == 2'd3) shreg <= ADDR_BYTE;
                    BYTE: begin
                        if (quarter == 2'd3) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ACK: begin
                        // slave holds its ACK while SCL is high; sample at end of Q2
                        if (quarter == 2'd2 && sda_in)
                            ack_error <= 1'b1;
                        if (quarter == 2'd3) begin
                            byte_cnt <= byte_cnt + 4'd1;
                            shreg    <= nxt_byte;
                        end
                    end
                    STOP: if (quarter == 2'd3) done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_gain_master.sv
// Bench for i2c_gain_master: behavioural equalizer slave on the bus plus a
// register-file reference model and bus-transaction expectations.
module tb_i2c_gain_master;

    localparam int CLK_DIV = 5;
    localparam int NG      = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8*NG-1:0] gain_data;
    logic          busy, done, ack_error, scl_out, sda_oe, sda_in;
    logic          slave_pull = 1'b0;
    logic          sda;

    int checks = 0;
    int errors = 0;

    assign sda    = ~(sda_oe | slave_pull);
    assign sda_in = sda;

    always #5 clk = ~clk;

    i2c_gain_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gain_data (gain_data),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_out   (scl_out),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    // Slave configuration, written by the stimulus only
    logic [6:0] s_addr   = 7'h6A;
    int         s_nack_g = -1;

    // Slave state, written by the slave process only
    logic [7:0] sregs [0:15] = '{default: 8'h00};
    logic [7:0] blog  [0:255];
    logic       p_scl = 1'b1, p_sda = 1'b1, in_xfer = 1'b0, ack_ph = 1'b0, addressed = 1'b0;
    logic [7:0] sr = 8'h00, ptr = 8'h00;
    int         bitn = 0, byten = 0;
    int         n_start = 0, n_stop = 0, n_ack = 0, n_log = 0;

    // Equalizer I2C slave: START/STOP detect, sample on SCL rise, ACK on SCL fall
    always @(posedge clk) begin
        p_scl <= scl_out;
        p_sda <= sda;
        if (rst) begin
            in_xfer    <= 1'b0;
            ack_ph     <= 1'b0;
            slave_pull <= 1'b0;
        end else if (p_scl && scl_out && p_sda && !sda) begin
            n_start    <= n_start + 1;
            in_xfer    <= 1'b1;
            bitn       <= 0;
            byten      <= 0;
            ack_ph     <= 1'b0;
            addressed  <= 1'b0;
            slave_pull <= 1'b0;
        end else if (p_scl && scl_out && !p_sda && sda) begin
            n_stop     <= n_stop + 1;
            in_xfer    <= 1'b0;
            ack_ph     <= 1'b0;
            slave_pull <= 1'b0;
        end else if (in_xfer && !p_scl && scl_out && !ack_ph) begin
            sr   <= {sr[6:0], sda};
            bitn <= bitn + 1;
        end else if (in_xfer && p_scl && !scl_out) begin
            if (ack_ph) begin
                slave_pull <= 1'b0;
                ack_ph     <= 1'b0;
            end else if (bitn == 8) begin
                bitn            <= 0;
                ack_ph          <= 1'b1;
                blog[n_log % 256] <= sr;
                n_log           <= n_log + 1;
                byten           <= byten + 1;
                if (byten == 0) begin
                    if (sr == {s_addr, 1'b0}) begin
                        addressed  <= 1'b1;
                        slave_pull <= 1'b1;
                        n_ack      <= n_ack + 1;
                    end
                end else if (addressed) begin
                    if (byten == 1) begin
                        ptr        <= sr;
                        slave_pull <= 1'b1;
                        n_ack      <= n_ack + 1;
                    end else if (byten - 2 != s_nack_g) begin
                        sregs[ptr[3:0]] <= sr;
                        ptr        <= ptr + 8'd1;
                        slave_pull <= 1'b1;
                        n_ack      <= n_ack + 1;
                    end else begin
                        addressed <= 1'b0;
                    end
                end
            end
        end
    end

    // Reference register file
    logic [7:0] exp_regs [0:15] = '{default: 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst. nack_g: gain index the slave refuses (-1 none); alt_at: cycle
    // of an extra start pulse; rst_at: cycle at which reset is sampled (0 none).
    task automatic run(input string tag, input logic [8*NG-1:0] g, input logic [6:0] addr,
                       input int nack_g, input int alt_at, input int rst_at);
        int cyc, nb, exp_cyc, exp_acks, st0, sp0, ak0, lg0;
        logic got_done;
        logic [7:0] eb;
        s_addr   = addr;
        s_nack_g = nack_g;
        st0 = n_start; sp0 = n_stop; ak0 = n_ack; lg0 = n_log;
        // bytes that reach the wire before the burst stops
        if (addr != 7'h6A)   nb = 1;
        else if (nack_g >= 0) nb = nack_g + 3;
        else                  nb = NG + 2;
        exp_acks = (nb == NG + 2) ? nb : nb - 1;
        exp_cyc  = (4 + 36 * nb + 4) * CLK_DIV;

        @(negedge clk);
        start     = 1'b1;
        gain_data = g;
        @(posedge clk); #1;
        start     = 1'b0;
        gain_data = ~g;
        chk({tag, "_busy_on_accept"}, busy, 1);
        chk({tag, "_ack_error_cleared"}, ack_error, 0);

        got_done = 1'b0;
        cyc      = 0;
        while (cyc < 3000 && !got_done) begin
            @(posedge clk); cyc++; #1;
            if (rst) begin
                chk({tag, "_rst_scl"}, scl_out, 1);
                chk({tag, "_rst_sda_oe"}, sda_oe, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_ack_error"}, ack_error, 0);
                rst = 1'b0;
                return;
            end
            if (start) start = 1'b0;
            if (done) got_done = 1'b1;
            else begin
                if (cyc == alt_at) begin
                    start     = 1'b1;
                    gain_data = {$urandom, $urandom, $urandom};
                end
                if (rst_at > 0 && cyc == rst_at - 1) rst = 1'b1;
            end
        end
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_ack_error"}, ack_error, (nb != NG + 2));

        // start while done is high must be dropped
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_start_on_done_dropped"}, busy, 0);
        chk({tag, "_ack_error_held"}, ack_error, (nb != NG + 2));
        repeat (3) @(posedge clk);
        #1;

        if (addr == 7'h6A) begin
            for (int k = 0; k < NG; k++) begin
                if (k == nack_g) break;
                exp_regs[1 + k] = g[8*k +: 8];
            end
        end
        for (int r = 1; r <= NG; r++)
            chk($sformatf("%s_reg%0d", tag, r), sregs[r], exp_regs[r]);
        chk({tag, "_bytes_on_bus"}, n_log - lg0, nb);
        for (int j = 0; j < nb && j < NG + 2; j++) begin
            if (j == 0)      eb = 8'hD4;
            else if (j == 1) eb = 8'h01;
            else             eb = g[8*(j-2) +: 8];
            chk($sformatf("%s_byte%0d", tag, j), blog[(lg0 + j) % 256], eb);
        end
        chk({tag, "_acks"}, n_ack - ak0, exp_acks);
        chk({tag, "_starts"}, n_start - st0, 1);
        chk({tag, "_stops"}, n_stop - sp0, 1);
    endtask

    initial begin
        logic [8*NG-1:0] g;
        int ng;
        rst       = 1'b1;
        start     = 1'b0;
        gain_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_scl", scl_out, 1);
        chk("reset_sda_oe", sda_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack_error", ack_error, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < NG; k++) g[8*k +: 8] = 8'd17;
        run("all17", g, 7'h6A, -1, 0, 0);

        for (int k = 0; k < NG; k++) g[8*k +: 8] = 8'(11 + k);
        run("ramp", g, 7'h6A, -1, 0, 0);

        g = {$urandom, $urandom, $urandom};
        run("addr_nack", g, 7'h6B, -1, 0, 0);

        g = {$urandom, $urandom, $urandom};
        run("data3_nack", g, 7'h6A, 3, 0, 0);

        g = {$urandom, $urandom, $urandom};
        run("second_start", g, 7'h6A, -1, 100, 0);

        g = {$urandom, $urandom, $urandom};
        run("mid_reset", g, 7'h6A, -1, 0, 700);
        repeat (5) @(posedge clk);
        #1;
        chk("after_reset_idle", busy, 0);

        g = {$urandom, $urandom, $urandom};
        run("fresh", g, 7'h6A, -1, 0, 0);

        for (int i = 0; i < 2; i++) begin
            g  = {$urandom, $urandom, $urandom};
            ng = $urandom_range(0, NG);
            run($sformatf("rand%0d", i), g, 7'h6A, (ng == NG) ? -1 : ng, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
